// File: rtl/grf_mp_scoreboard.sv
// General register file with two write ports, combinational read ports with
// same-cycle bypass, a per-register pending scoreboard and a write-commit log.
module grf_mp_scoreboard #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*ADDR_W-1:0] ra,
   output logic [NUM_RD*DATA_W-1:0] rd,
   output logic [NUM_RD-1:0]        rd_pend,
   input  logic                     we0,
   input  logic [ADDR_W-1:0]        wa0,
   input  logic [DATA_W-1:0]        wd0,
   input  logic [31:0]              pc0,
   input  logic                     we1,
   input  logic [ADDR_W-1:0]        wa1,
   input  logic [DATA_W-1:0]        wd1,
   input  logic [31:0]              pc1,
   input  logic                     rsv,
   input  logic [ADDR_W-1:0]        rsv_a,
   output logic [1:0]               log_v,
   output logic [2*ADDR_W-1:0]      log_a,
   output logic [2*DATA_W-1:0]      log_d,
   output logic [63:0]              log_pc
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam bit ZR    = (ZERO_REG != 0);

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  pending;

   logic store0, store1, reserve;
   assign store0  = we0 && !(ZR && wa0 == '0);
   assign store1  = we1 && !(ZR && wa1 == '0);
   assign reserve = rsv && !(ZR && rsv_a == '0);

   // Port 0 is written last so it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else begin
         if (store1) regs[wa1] <= wd1;
         if (store0) regs[wa0] <= wd0;
      end
   end

   // Clear from the late writeback first, then reserve, so a reserve wins.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pending <= '0;
      end else begin
         if (we1)     pending[wa1]   <= 1'b0;
         if (reserve) pending[rsv_a] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         log_v  <= '0;
         log_a  <= '0;
         log_d  <= '0;
         log_pc <= '0;
      end else begin
         log_v <= {we1, we0};
         if (we0) begin
            log_a[0 +: ADDR_W]  <= wa0;
            log_d[0 +: DATA_W]  <= wd0;
            log_pc[0 +: 32]     <= pc0;
         end
         if (we1) begin
            log_a[ADDR_W +: ADDR_W] <= wa1;
            log_d[DATA_W +: DATA_W] <= wd1;
            log_pc[32 +: 32]        <= pc1;
         end
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic              p;

      assign a = ra[k*ADDR_W +: ADDR_W];

      // Later assignments override earlier ones, giving the bypass priority.
      always_comb begin
         d = regs[a];
         p = pending[a];
         if (we1 && wa1 == a) begin
            d = wd1;
            p = 1'b0;
         end
         if (rsv && rsv_a == a) p = 1'b1;
         if (we0 && wa0 == a) d = wd0;
         if (ZR && a == '0) begin
            d = '0;
            p = 1'b0;
         end
      end

      assign rd[k*DATA_W +: DATA_W] = d;
      assign rd_pend[k]             = p;
   end

endmodule

// File: doc/grf_mp_scoreboard.md
Name: grf_mp_scoreboard

Overview:
- Parametrised general register file for the pipelined CPU.
- Provides NUM_RD combinational read ports and two write ports:
  - port 0: the W-stage writeback.
  - port 1: the late/multicycle unit writeback (mult/div, load-miss).
- Per-register pending scoreboard; the hazard unit uses the pending flags to stall.
- Registered write-commit log for the testbench trace.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; DEPTH = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1: register 0 is hardwired to 0 and never pending; 0: register 0 is an ordinary register

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-low reset
ra  in  NUM_RD*ADDR_W  packed read addresses; port k = ra[k*ADDR_W +: ADDR_W]
rd  out  NUM_RD*DATA_W  packed read data, combinational
rd_pend  out  NUM_RD  read port k's register is pending (after this cycle's clear/reserve rules)
we0  in  1  write enable, port 0
wa0  in  ADDR_W  write address, port 0
wd0  in  DATA_W  write data, port 0
pc0  in  32  PC of the instruction writing through port 0 (log only)
we1  in  1  write enable, port 1; also clears pending[wa1]
wa1  in  ADDR_W  write address, port 1
wd1  in  DATA_W  write data, port 1
pc1  in  32  PC for port 1 (log only)
rsv  in  1  reserve request: set pending[rsv_a]
rsv_a  in  ADDR_W  register to reserve
log_v  out  2  bit j: port j committed a write last cycle
log_a  out  2*ADDR_W  logged addresses, packed per port
log_d  out  2*DATA_W  logged data, packed per port
log_pc  out  64  logged PCs, packed per port

Behaviour:
- Reset (reset==0 at posedge):
  - all registers <= 0, all pending <= 0, log_v <= 0.
  - log_a, log_d, log_pc <= 0.
  - Writes, reserves and clears in that cycle are ignored.
- Zero register (ZERO_REG=1):
  - Writes to address 0 are dropped; no storage change.
  - Reads of address 0 return 0 with rd_pend=0, bypass included.
  - rsv to address 0 is ignored.
  - The log still records the write with the data as presented; the trace matches MARS behaviour.
- Write: at posedge, we0 stores wd0 to wa0 and we1 stores wd1 to wa1.
- Same-address collision (we0 && we1 && wa0==wa1): port 0 data is stored; the port 1 data is lost; both log channels fire.
- Read bypass, per port k, priority highest first:
  - (a) ZERO_REG && ra==0 -> 0
  - (b) we0 && wa0==ra -> wd0
  - (c) we1 && wa1==ra -> wd1
  - (d) array contents
  - Read latency is 0 cycles; a value written in cycle N is visible in cycle N via bypass and from storage from N+1.
- Scoreboard update at posedge:
  - pending[wa1] <= 0 if we1.
  - Then pending[rsv_a] <= 1 if rsv. A reserve wins over a clear to the same address in the same cycle.
  - A port 0 write does not affect pending.
- rd_pend[k]:
  - = pending[ra] with same-cycle forwarding:
    - if we1 && wa1==ra, report 0;
    - if rsv && rsv_a==ra, report 1 (reserve wins over clear).
  - Forced to 0 for address 0 when ZERO_REG=1.
- Log:
  - log_v[j] <= we_j each non-reset cycle.
  - Address, data and PC for channel j are captured only when we_j=1; otherwise they hold.
  - One-cycle latency.
- A reserve with no later clear stays pending indefinitely. Only reset or a we1 to that address clears it.
- Reset asserted mid-operation discards all outstanding reservations.

Test Plan:
- Reset then read: hold reset=0 one cycle, then read ra={5'd3,5'd0} -> rd all 0, rd_pend 0, log_v=00.
- Write + bypass: we0=1, wa0=5, wd0=32'hDEADBEEF, ra port0=5 -> rd port0=32'hDEADBEEF the same cycle; the next cycle it reads from storage; log_v=01, log_a=5, log_pc=pc0.
- Zero register: we0=1, wa0=0, wd0=32'h1234 -> read of reg 0 returns 0 the same and next cycle; log_v[0]=1 with log_d=32'h1234; rsv_a=0 -> rd_pend stays 0.
- Collision: we0 and we1 both to reg 7, wd0=32'h11, wd1=32'h22 -> reg 7=32'h11; bypass read gives 32'h11; log_v=11 with both data values.
- Scoreboard: rsv reg 9 -> rd_pend=1 from the same cycle on. Later we1 wa1=9 wd1=32'h55 -> rd_pend=0 and rd=32'h55 the same cycle. we1 and rsv to reg 9 together -> pending stays 1 and the data is stored.
- Reset mid-operation: reserve regs 4 and 6, write reg 4=32'hA, assert reset -> next cycle regs are 0, rd_pend 0 for both, log_v=00.
